// File: rtl/trena_pkg.sv
// Shared constants for the multi-channel tape-measure control unit: state codes
// and the display code shown for an out-of-range state.
package trena_pkg;

  localparam logic [3:0] StInicial           = 4'd0;
  localparam logic [3:0] StFazMedida         = 4'd1;
  localparam logic [3:0] StAguardaMedida     = 4'd2;
  localparam logic [3:0] StTransmite         = 4'd3;
  localparam logic [3:0] StEsperaTransmissao = 4'd4;
  localparam logic [3:0] StProximoCanal      = 4'd5;
  localparam logic [3:0] StFim               = 4'd6;
  localparam logic [3:0] StEsperaPeriodo     = 4'd7;

  localparam logic [3:0] DB_INVALIDO = 4'hE;

endpackage

// File: rtl/trena_contador_limite.sv
// Up-counter with synchronous clear and enable; flags when the value equals Limite-1.
// It wraps past the terminal count; the owning FSM always leaves or clears first.
module trena_contador_limite #(
  parameter int unsigned Limite = 2,
  parameter int unsigned W      = (Limite > 1) ? $clog2(Limite) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic limpar_i,
  input  logic habilitar_i,
  output logic terminal_o
);

  localparam logic [W-1:0] Terminal = W'(Limite - 1);

  logic [W-1:0] valor_q, valor_d;

  always_comb begin
    valor_d = valor_q;
    if (limpar_i) begin
      valor_d = '0;
    end else if (habilitar_i) begin
      valor_d = valor_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign terminal_o = (valor_q == Terminal);

endmodule

// File: rtl/trena_multicanal_uc.sv
// Control unit sweeping N_CANAIS ultrasonic sensors and framing each result for the UART.
// Define TRENA_TIMEOUT_FRAME_EN to still send a (datapath-substituted) frame on timeout.
module trena_multicanal_uc #(
  parameter int unsigned N_CANAIS       = 4,
  parameter int unsigned CHAR_COUNT     = 7,
  parameter int unsigned TIMEOUT_CICLOS = 50000,
  parameter int unsigned PERIODO_CICLOS = 5000000,
  parameter int unsigned CW             = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1,
  parameter int unsigned IW             = (CHAR_COUNT > 1) ? $clog2(CHAR_COUNT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ligar,
  input  logic          mensurar,
  input  logic          modo_continuo,
  input  logic          medida_pronto,
  input  logic          detecta,
  input  logic          envio_pronto,
  output logic          medir,
  output logic [CW-1:0] canal,
  output logic          transmitir,
  output logic [IW-1:0] indice_caractere,
  output logic          alerta,
  output logic          timeout,
  output logic          pronto,
  output logic [3:0]    db_estado
);

  import trena_pkg::*;

  localparam logic [CW-1:0] UltimoCanal = CW'(N_CANAIS - 1);
  localparam logic [IW-1:0] UltimoChar  = IW'(CHAR_COUNT - 1);

  logic [3:0]    estado_q, estado_d;
  logic [CW-1:0] canal_q, canal_d;
  logic [IW-1:0] indice_q, indice_d;
  logic          alerta_q, alerta_d;
  logic          timeout_q, timeout_d;
  logic          limpa_to, conta_to, fim_to;
  logic          limpa_per, conta_per, fim_per;

  trena_contador_limite #(.Limite(TIMEOUT_CICLOS)) u_cont_timeout (
    .clock       (clock),
    .reset       (reset),
    .limpar_i    (limpa_to),
    .habilitar_i (conta_to),
    .terminal_o  (fim_to)
  );

  trena_contador_limite #(.Limite(PERIODO_CICLOS)) u_cont_periodo (
    .clock       (clock),
    .reset       (reset),
    .limpar_i    (limpa_per),
    .habilitar_i (conta_per),
    .terminal_o  (fim_per)
  );

  always_comb begin
    estado_d  = estado_q;
    canal_d   = canal_q;
    indice_d  = indice_q;
    alerta_d  = alerta_q;
    timeout_d = 1'b0;
    limpa_to  = 1'b0;
    conta_to  = 1'b0;
    limpa_per = 1'b0;
    conta_per = 1'b0;
    if (!ligar) begin
      estado_d  = StInicial;
      canal_d   = '0;
      indice_d  = '0;
      alerta_d  = 1'b0;
      limpa_to  = 1'b1;
      limpa_per = 1'b1;
    end else begin
      case (estado_q)
        StInicial: begin
          if (mensurar || modo_continuo) begin
            estado_d = StFazMedida;
            canal_d  = '0;
          end
        end
        StFazMedida: begin
          limpa_to = 1'b1;
          estado_d = StAguardaMedida;
        end
        StAguardaMedida: begin
          conta_to = 1'b1;
          // A result arriving on the terminal cycle still counts as a measurement.
          if (medida_pronto) begin
            estado_d = StTransmite;
            alerta_d = detecta;
            indice_d = '0;
          end else if (fim_to) begin
            timeout_d = 1'b1;
`ifdef TRENA_TIMEOUT_FRAME_EN
            estado_d  = StTransmite;
            indice_d  = '0;
            alerta_d  = 1'b0;
`else
            estado_d  = StProximoCanal;
`endif
          end
        end
        StTransmite: estado_d = StEsperaTransmissao;
        StEsperaTransmissao: begin
          if (envio_pronto) begin
            if (indice_q == UltimoChar) begin
              estado_d = StProximoCanal;
            end else begin
              indice_d = indice_q + IW'(1);
              estado_d = StTransmite;
            end
          end
        end
        StProximoCanal: begin
          alerta_d = 1'b0;
          if (canal_q == UltimoCanal) begin
            estado_d = StFim;
          end else begin
            canal_d  = canal_q + CW'(1);
            estado_d = StFazMedida;
          end
        end
        StFim: begin
          canal_d = '0;
          if (modo_continuo) begin
            limpa_per = 1'b1;
            estado_d  = StEsperaPeriodo;
          end else begin
            estado_d = StInicial;
          end
        end
        StEsperaPeriodo: begin
          conta_per = 1'b1;
          if (!modo_continuo) begin
            estado_d = StInicial;
          end else if (fim_per) begin
            estado_d = StFazMedida;
          end
        end
        default: estado_d = StInicial;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= StInicial;
      canal_q   <= '0;
      indice_q  <= '0;
      alerta_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      canal_q   <= canal_d;
      indice_q  <= indice_d;
      alerta_q  <= alerta_d;
      timeout_q <= timeout_d;
    end
  end

  assign medir            = (estado_q == StFazMedida);
  assign transmitir       = (estado_q == StTransmite);
  assign pronto           = (estado_q == StFim);
  assign canal            = canal_q;
  assign indice_caractere = indice_q;
  assign alerta           = alerta_q;
  assign timeout          = timeout_q;
  assign db_estado        = (estado_q <= StEsperaPeriodo) ? estado_q : DB_INVALIDO;

endmodule

// File: tb/tb_trena_multicanal_uc.sv
// Directed bench for trena_multicanal_uc with 2 channels, 3-char frames, timeout 20, period 10.
module tb_trena_multicanal_uc;

  logic       clock = 1'b0;
  logic       reset;
  logic       ligar, mensurar, modo_continuo, medida_pronto, detecta, envio_pronto;
  logic       medir, transmitir, alerta, timeout, pronto;
  logic [0:0] canal;
  logic [1:0] indice_caractere;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   n_medir, n_tx, n_pronto, n_timeout;
  int   first_medir_cyc, pronto_cyc, t_aguarda0, t_timeout;
  int   tx_canal[$];
  int   tx_ind[$];
  logic tx_al[$];

`ifdef TRENA_TIMEOUT_FRAME_EN
  localparam int   ExpTxTimeout = 6;
  localparam int   ExpCanalTx0  = 0;
  localparam logic ExpAlertaTx0 = 1'b0;
`else
  localparam int   ExpTxTimeout = 3;
  localparam int   ExpCanalTx0  = 1;
  localparam logic ExpAlertaTx0 = 1'b1;
`endif

  trena_multicanal_uc #(
    .N_CANAIS       (2),
    .CHAR_COUNT     (3),
    .TIMEOUT_CICLOS (20),
    .PERIODO_CICLOS (10)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .ligar            (ligar),
    .mensurar         (mensurar),
    .modo_continuo    (modo_continuo),
    .medida_pronto    (medida_pronto),
    .detecta          (detecta),
    .envio_pronto     (envio_pronto),
    .medir            (medir),
    .canal            (canal),
    .transmitir       (transmitir),
    .indice_caractere (indice_caractere),
    .alerta           (alerta),
    .timeout          (timeout),
    .pronto           (pronto),
    .db_estado        (db_estado)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Plays sensor and transmitter: medida_pronto `atraso` cycles after medir, envio_pronto
  // 4 cycles after transmitir. Returns on pronto, or on abort when ligar is dropped.
  task automatic run_sweep(input int atraso, input logic [1:0] sem_resp, input logic [1:0] det,
                           input bit abortar, input int budget);
    int  cd_med = 0;
    int  cd_env = 0;
    bit  done = 0;
    n_medir = 0; n_tx = 0; n_pronto = 0; n_timeout = 0;
    first_medir_cyc = -1; pronto_cyc = -1; t_aguarda0 = -1; t_timeout = -1;
    tx_canal.delete(); tx_ind.delete(); tx_al.delete();
    for (int i = 0; i < budget && !done; i++) begin
      step();
      mensurar = 0; medida_pronto = 0; envio_pronto = 0; detecta = 0;
      if (cd_med > 0) begin
        cd_med--;
        if (cd_med == 0) begin
          medida_pronto = 1;
          detecta = det[canal];
        end
      end
      if (cd_env > 0) begin
        cd_env--;
        if (cd_env == 0) envio_pronto = 1;
      end
      if (medir) begin
        n_medir++;
        if (first_medir_cyc < 0) first_medir_cyc = cyc;
        if (!sem_resp[canal]) cd_med = atraso;
      end
      if (db_estado == 4'd2 && t_aguarda0 < 0) t_aguarda0 = cyc;
      if (timeout) begin
        n_timeout++;
        t_timeout = cyc;
      end
      if (transmitir) begin
        n_tx++;
        tx_canal.push_back(int'(canal));
        tx_ind.push_back(int'(indice_caractere));
        tx_al.push_back(alerta);
        cd_env = 4;
      end
      if (pronto) begin
        n_pronto++;
        pronto_cyc = cyc;
        done = 1;
      end
      if (abortar && db_estado == 4'd4 && canal == 1'b1) begin
        ligar = 0;
        done = 1;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL sweep_budget: sweep did not end within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1; ligar = 1; mensurar = 1; modo_continuo = 0;
    medida_pronto = 0; detecta = 0; envio_pronto = 0;
    step(); step();
    total++;
    if ({medir, transmitir, alerta, timeout, pronto} !== 5'b0) begin
      bad++;
      $display("FAIL reset_pulses: got %b want 00000", {medir, transmitir, alerta, timeout, pronto});
    end
    total++;
    if ({canal, indice_caractere, db_estado} !== 7'b0) begin
      bad++;
      $display("FAIL reset_idx: canal=%0d indice=%0d db=%0d want 0", canal, indice_caractere,
               db_estado);
    end
    mensurar = 0;
    reset = 0;
    step(); step();
    total++;
    if (db_estado !== 4'd0) begin
      bad++;
      $display("FAIL idle_no_request: db_estado=%0d want 0", db_estado);
    end
  endtask

  task automatic test_single_sweep();
    bit ok = 1;
    mensurar = 1;
    run_sweep(5, 2'b00, 2'b00, 0, 300);
    total++;
    if (n_medir !== 2) begin
      bad++; $display("FAIL single_medir: got %0d want 2", n_medir);
    end
    total++;
    if (n_tx !== 6) begin
      bad++; $display("FAIL single_tx: got %0d want 6", n_tx);
    end
    for (int i = 0; i < 6; i++) begin
      if (tx_ind[i] !== i % 3 || tx_canal[i] !== i / 3) ok = 0;
    end
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL single_order: got indices %p canals %p want 0,1,2 x canal 0,1",
                      tx_ind, tx_canal);
    end
    total++;
    if (n_pronto !== 1 || n_timeout !== 0) begin
      bad++; $display("FAIL single_pronto: pronto=%0d timeout=%0d want 1 0", n_pronto, n_timeout);
    end
    step();
    total++;
    if (db_estado !== 4'd0 || canal !== 1'b0) begin
      bad++; $display("FAIL single_return: db=%0d canal=%0d want 0 0", db_estado, canal);
    end
  endtask

  task automatic test_alert();
    bit ok = 1;
    mensurar = 1;
    run_sweep(5, 2'b00, 2'b10, 0, 300);
    for (int i = 0; i < 6; i++) begin
      if (tx_al[i] !== (i >= 3)) ok = 0;
    end
    total++;
    if (ok !== 1'b1 || n_tx !== 6) begin
      bad++; $display("FAIL alert_frames: got %p (n=%0d) want 0,0,0,1,1,1", tx_al, n_tx);
    end
    total++;
    if (alerta !== 1'b0) begin
      bad++; $display("FAIL alert_cleared: alerta=%b want 0", alerta);
    end
    step();
  endtask

  task automatic test_timeout();
    mensurar = 1;
    run_sweep(5, 2'b01, 2'b10, 0, 300);
    total++;
    if (n_timeout !== 1 || t_timeout - t_aguarda0 !== 20) begin
      bad++; $display("FAIL timeout_pulse: count=%0d delay=%0d want 1 20", n_timeout,
                      t_timeout - t_aguarda0);
    end
    total++;
    if (n_tx !== ExpTxTimeout) begin
      bad++; $display("FAIL timeout_tx: got %0d want %0d", n_tx, ExpTxTimeout);
    end
    total++;
    if (tx_canal[0] !== ExpCanalTx0 || tx_al[0] !== ExpAlertaTx0) begin
      bad++; $display("FAIL timeout_first_frame: canal=%0d alerta=%b want %0d %b", tx_canal[0],
                      tx_al[0], ExpCanalTx0, ExpAlertaTx0);
    end
    total++;
    if (n_medir !== 2) begin
      bad++; $display("FAIL timeout_medir: got %0d want 2", n_medir);
    end
    step();
  endtask

  task automatic test_continuous();
    int p1;
    modo_continuo = 1;
    run_sweep(5, 2'b00, 2'b00, 0, 300);
    p1 = pronto_cyc;
    run_sweep(5, 2'b00, 2'b00, 0, 300);
    total++;
    if (first_medir_cyc - p1 !== 11) begin
      bad++; $display("FAIL cont_period: got %0d want 11", first_medir_cyc - p1);
    end
    total++;
    if (n_pronto !== 1 || n_tx !== 6) begin
      bad++; $display("FAIL cont_second_sweep: pronto=%0d tx=%0d want 1 6", n_pronto, n_tx);
    end
    step(); step();
    total++;
    if (db_estado !== 4'd7) begin
      bad++; $display("FAIL cont_wait_state: db=%0d want 7", db_estado);
    end
    modo_continuo = 0;
    step();
    total++;
    if (db_estado !== 4'd0) begin
      bad++; $display("FAIL cont_drop: db=%0d want 0", db_estado);
    end
  endtask

  task automatic test_abort();
    int prontos = 0;
    mensurar = 1;
    run_sweep(5, 2'b00, 2'b10, 1, 300);
    step();
    total++;
    if (db_estado !== 4'd0 || alerta !== 1'b0) begin
      bad++; $display("FAIL abort_state: db=%0d alerta=%b want 0 0", db_estado, alerta);
    end
    total++;
    if (canal !== 1'b0 || indice_caractere !== 2'd0) begin
      bad++; $display("FAIL abort_idx: canal=%0d indice=%0d want 0 0", canal, indice_caractere);
    end
    for (int i = 0; i < 10; i++) begin
      if (pronto) prontos++;
      step();
    end
    total++;
    if (prontos !== 0) begin
      bad++; $display("FAIL abort_no_pronto: got %0d want 0", prontos);
    end
    ligar = 1;
    step();
  endtask

  task automatic test_coincidence();
    mensurar = 1;
    run_sweep(20, 2'b00, 2'b00, 0, 400);
    total++;
    if (n_timeout !== 0) begin
      bad++; $display("FAIL coinc_timeout: got %0d want 0", n_timeout);
    end
    total++;
    if (n_tx !== 6) begin
      bad++; $display("FAIL coinc_tx: got %0d want 6", n_tx);
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_alert();
    test_timeout();
    test_continuous();
    test_abort();
    test_coincidence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trena_multicanal_uc.md
Name: trena_multicanal_uc

Overview:
- Parametrised control unit for a multi-sensor digital tape measure.
- Sweeps N_CANAIS ultrasonic channels in turn: triggers a measurement, waits with timeout, then transmits a CHAR_COUNT-character frame per channel with a per-channel alert flag.
- Supports single-shot (mensurar) and continuous periodic sweeps.
- Sits between the sensor interfaces/mux and the serial transmitter in the datapath.

Parameters:
- N_CANAIS, 4, number of sensor channels; >=1.
- CHAR_COUNT, 7, characters transmitted per channel frame; >=1.
- TIMEOUT_CICLOS, 50000, cycles waited for medida_pronto before declaring timeout.
- PERIODO_CICLOS, 5000000, idle cycles between sweeps in continuous mode.
- CW, $clog2(N_CANAIS) min 1, channel index width (derived).
- IW, $clog2(CHAR_COUNT) min 1, character index width (derived).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- ligar  in  1  enable; low forces return to INICIAL.
- mensurar  in  1  single-sweep request (level, sampled in INICIAL).
- modo_continuo  in  1  1 = repeat sweeps every PERIODO_CICLOS.
- medida_pronto  in  1  sensor measurement complete (1-cycle pulse).
- detecta  in  1  distance below threshold; valid with medida_pronto.
- envio_pronto  in  1  transmitter finished current character (1-cycle pulse).
- medir  out  1  1-cycle trigger to selected sensor.
- canal  out  CW  selected channel index.
- transmitir  out  1  1-cycle start pulse for one character.
- indice_caractere  out  IW  index of character being sent.
- alerta  out  1  high for the whole frame of a channel whose detecta was 1.
- timeout  out  1  1-cycle pulse when a channel times out.
- pronto  out  1  1-cycle pulse at end of sweep.
- db_estado  out  4  state code for the 7-segment display.

Behaviour:
- Reset: all outputs 0; canal=0, indice_caractere=0; all counters 0; state INICIAL.
- INICIAL (0): if ligar & (mensurar | modo_continuo) -> FAZ_MEDIDA, canal=0.
- FAZ_MEDIDA (1): medir=1 for one cycle; timeout counter cleared; -> AGUARDA_MEDIDA.
- AGUARDA_MEDIDA (2): counter increments each cycle. medida_pronto -> TRANSMITE, latch alerta<=detecta, indice=0. Else counter==TIMEOUT_CICLOS-1 -> pulse timeout, -> PROXIMO_CANAL (no frame sent). If medida_pronto and timeout coincide, medida_pronto wins.
- TRANSMITE (3): transmitir=1 for one cycle; -> ESPERA_TRANSMISSAO.
- ESPERA_TRANSMISSAO (4): on envio_pronto: if indice==CHAR_COUNT-1 -> PROXIMO_CANAL; else indice++ and -> TRANSMITE.
- PROXIMO_CANAL (5): alerta<=0. If canal==N_CANAIS-1 -> FIM, else canal++ and -> FAZ_MEDIDA.
- FIM (6): pronto=1 for one cycle; canal<=0. If modo_continuo -> ESPERA_PERIODO (period counter cleared), else -> INICIAL.
- ESPERA_PERIODO (7): counter increments. At PERIODO_CICLOS-1 -> FAZ_MEDIDA. If modo_continuo drops -> INICIAL.
- Invalid codes (8-15) -> INICIAL; db_estado=4'hE.
- ligar low in any state: -> INICIAL next cycle. Pending frame is aborted, alerta cleared, counters and canal cleared.
- mensurar is ignored outside INICIAL; a level held through FIM starts a new sweep immediately after returning to INICIAL.
- envio_pronto outside ESPERA_TRANSMISSAO and medida_pronto outside AGUARDA_MEDIDA are ignored.
- Counters saturate-free and sized by $clog2 of their terminal count; compares are equality.

Optional Feature:
- Macro: TRENA_TIMEOUT_FRAME_EN.
- Defined: on timeout, the block transmits the channel frame anyway (TRANSMITE path, indice=0) with alerta=0, and the datapath substitutes an error pattern.
- Undefined: a timed-out channel sends no frame, as specified above.
- The timeout pulse is identical in both builds.

Decomposition:
- Package trena_pkg holds the state enum (4-bit codes 0-7 as listed) and the DB_INVALIDO=4'hE constant.
- One sub-module: trena_contador_limite (parametrised up-counter with clear, enable and terminal-count flag). It is instantiated twice: timeout counter and period counter.
- Channel and character indices stay inline.

Test Plan (N_CANAIS=2, CHAR_COUNT=3, TIMEOUT_CICLOS=20, PERIODO_CICLOS=10):
- Single sweep: mensurar pulse, medida_pronto 5 cycles after each medir, envio_pronto 4 cycles after each transmitir -> 2 medir pulses, 6 transmitir pulses, indice 0,1,2 per frame, canal 0 then 1, one pronto, back to INICIAL (db_estado=0).
- Alert: detecta=1 with medida_pronto on canal 1 only -> alerta high across all 3 characters of frame 1, low during frame 0.
- Timeout: no medida_pronto on canal 0 -> timeout pulse exactly 20 cycles after entering AGUARDA_MEDIDA, no transmitir for canal 0, canal 1 measured normally. With TRENA_TIMEOUT_FRAME_EN defined, 3 transmitir pulses follow with alerta=0.
- Continuous: modo_continuo=1 -> pronto, then medir for canal 0 again 10 cycles + 1 later. Dropping modo_continuo in ESPERA_PERIODO -> INICIAL.
- Abort: ligar=0 during ESPERA_TRANSMISSAO of canal 1 -> next cycle db_estado=0, alerta=0, canal=0, no pronto.
- Coincidence: medida_pronto on the same cycle as terminal timeout count -> frame sent, no timeout pulse.
